// File: rtl/stepper_pkg.sv
// Shared constants and types for the stepper phase sequencer.
// Used by stepper_channel and stepper_phase_decode.
package stepper_pkg;

  localparam logic [3:0] STEP_RESET_POS = 4'd2;

  localparam logic [3:0] STEP_INC_FULL = 4'd4;
  localparam logic [3:0] STEP_INC_HALF = 4'd2;
  localparam logic [3:0] STEP_INC_QTR  = 4'd1;

  localparam logic [3:0] MS_FULL = 4'd1;
  localparam logic [3:0] MS_HALF = 4'd2;
  localparam logic [3:0] MS_QTR  = 4'd4;

  // {p1_I0, p1_I1, p1_phase, p2_I0, p2_I1, p2_phase}
  typedef logic [5:0] phase_word_t;

  // Unrecognised selector codes fall back to full stepping.
  function automatic logic [3:0] step_increment(input logic [3:0] microstep);
    case (microstep)
      MS_HALF: step_increment = STEP_INC_HALF;
      MS_QTR:  step_increment = STEP_INC_QTR;
      default: step_increment = STEP_INC_FULL;
    endcase
  endfunction

endpackage

// File: rtl/stepper_phase_decode.sv
// Combinational map from quarter-step table position to the six phase lines.
// STEPPER_CHANNEL_MODIFIED_EN lets modified_mode drive I0 at positions 2/6/10/14.
module stepper_phase_decode
  import stepper_pkg::*;
(
  input  logic [3:0]  pos,
  input  logic        modified_mode,
  output phase_word_t word
);

  logic m;

`ifdef STEPPER_CHANNEL_MODIFIED_EN
  assign m = modified_mode;
`else
  logic unused_mode;
  assign unused_mode = modified_mode;
  assign m           = 1'b0;
`endif

  // NOTE: full case with a default keeps this purely combinational; a missing
  // branch in always_comb would infer a latch on word.
  always_comb begin
    word = 6'b000000;
    case (pos)
      4'd0:    word = 6'b110001;
      4'd1:    word = 6'b011001;
      4'd2:    word = {m, 2'b01, m, 2'b01};
      4'd3:    word = 6'b001011;
      4'd4:    word = 6'b001110;
      4'd5:    word = 6'b001010;
      4'd6:    word = {m, 2'b01, m, 2'b00};
      4'd7:    word = 6'b011000;
      4'd8:    word = 6'b110000;
      4'd9:    word = 6'b010000;
      4'd10:   word = {m, 2'b00, m, 2'b00};
      4'd11:   word = 6'b000010;
      4'd12:   word = 6'b000110;
      4'd13:   word = 6'b000011;
      4'd14:   word = {m, 2'b00, m, 2'b01};
      4'd15:   word = 6'b010001;
      default: word = 6'b000000;
    endcase
  end

endmodule

// File: rtl/stepper_channel.sv
// Single-axis stepper phase sequencer: synchronises step pulses and walks a
// 16-position quarter-step table. Optional feature: STEPPER_CHANNEL_MODIFIED_EN.
module stepper_channel
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic [3:0] microstep,
  input  logic       modified_mode,
  output logic       phase1_I0,
  output logic       phase1_I1,
  output logic       phase1_phase,
  output logic       phase2_I0,
  output logic       phase2_I1,
  output logic       phase2_phase
);

  logic        s1, s2, s3;
  logic        step_edge;
  logic [3:0]  pos, pos_next, decode_pos;
  phase_word_t word_next, word_q;

  assign step_edge = s2 & ~s3;

  always_comb begin
    pos_next = pos;
    if (step_edge)
      pos_next = dir ? pos + step_increment(microstep)
                     : pos - step_increment(microstep);
  end

  // The output register tracks the next position so pos and outputs move on
  // the same edge; under reset it shows the home word for the live mode bit.
  assign decode_pos = rst ? STEP_RESET_POS : pos_next;

  stepper_phase_decode u_decode (
    .pos           (decode_pos),
    .modified_mode (modified_mode),
    .word          (word_next)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // blocking here would collapse the synchroniser chain into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      pos <= STEP_RESET_POS;
    end else begin
      s1  <= step;
      s2  <= s1;
      s3  <= s2;
      pos <= pos_next;
    end
    word_q <= word_next;
  end

  assign {phase1_I0, phase1_I1, phase1_phase,
          phase2_I0, phase2_I1, phase2_phase} = word_q;

endmodule

// File: tb/tb_stepper_channel.sv
// Self-checking bench for stepper_channel: directed and random step pulses
// compared against a table-position reference model.
module tb_stepper_channel;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic       dir;
  logic [3:0] microstep;
  logic       modified_mode;
  logic       phase1_I0, phase1_I1, phase1_phase;
  logic       phase2_I0, phase2_I1, phase2_phase;
  logic [5:0] obs;

  int vectors     = 0;
  int miscompares = 0;
  int model_pos   = 2;

  // Phase words per position with the modified-profile bits cleared.
  localparam logic [5:0] BASE_TBL [16] = '{
    6'b110001, 6'b011001, 6'b001001, 6'b001011,
    6'b001110, 6'b001010, 6'b001000, 6'b011000,
    6'b110000, 6'b010000, 6'b000000, 6'b000010,
    6'b000110, 6'b000011, 6'b000001, 6'b010001
  };

  stepper_channel dut (
    .clk           (clk),
    .rst           (rst),
    .step          (step),
    .dir           (dir),
    .microstep     (microstep),
    .modified_mode (modified_mode),
    .phase1_I0     (phase1_I0),
    .phase1_I1     (phase1_I1),
    .phase1_phase  (phase1_phase),
    .phase2_I0     (phase2_I0),
    .phase2_I1     (phase2_I1),
    .phase2_phase  (phase2_phase)
  );

  assign obs = {phase1_I0, phase1_I1, phase1_phase, phase2_I0, phase2_I1, phase2_phase};

  always #5 clk = ~clk;

  function automatic logic [5:0] model_word(input int p, input logic m);
    logic [5:0] w;
    w = BASE_TBL[p];
`ifdef STEPPER_CHANNEL_MODIFIED_EN
    if (m && (p % 4 == 2)) w = w | 6'b100100;
`endif
    return w;
  endfunction

  function automatic int model_inc(input logic [3:0] ms);
    if (ms == 4'd1) return 4;
    if (ms == 4'd2) return 2;
    if (ms == 4'd4) return 1;
    return 4;
  endfunction

  function automatic int model_move(input int p, input logic d, input logic [3:0] ms);
    return d ? (p + model_inc(ms)) % 16 : (p - model_inc(ms) + 16) % 16;
  endfunction

  task automatic check(input string tag, input logic [5:0] expected);
    vectors++;
    assert (obs === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (pos %0d)", tag, obs, expected, model_pos);
    end
  endtask

  // Legal pulse: controls settle 2 clk ahead, step high 2 clk, low 2 clk.
  task automatic pulse(input string tag, input logic d, input logic [3:0] ms, input logic mm);
    @(negedge clk);
    dir = d; microstep = ms; modified_mode = mm;
    @(negedge clk);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    step = 1'b0;
    check({tag, "_latency"}, model_word(model_pos, mm));
    model_pos = model_move(model_pos, d, ms);
    @(negedge clk);
    check(tag, model_word(model_pos, mm));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; dir = 1'b0; microstep = 4'd1; modified_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_pos = 2;
    check("reset", 6'b001001);

    for (int i = 0; i < 50; i++) pulse("full_dn", 1'b0, 4'd1, 1'b0);
    for (int i = 0; i < 50; i++) pulse("full_up", 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 50; i++) pulse("half_dn", 1'b0, 4'd2, 1'b0);
    for (int i = 0; i < 50; i++) pulse("half_up", 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 50; i++) pulse("qtr_dn",  1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 50; i++) pulse("qtr_up",  1'b1, 4'd4, 1'b0);

    for (int i = 0; i < 100; i++)
      pulse("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));

    // Walk to position 10 and toggle the profile bit with no step activity.
    for (int i = 0; i < 16 && model_pos != 10; i++) pulse("seek10", 1'b1, 4'd4, 1'b0);
    @(negedge clk);
    modified_mode = 1'b1;
    @(negedge clk);
    check("mod_on_pos10", model_word(10, 1'b1));
    modified_mode = 1'b0;
    @(negedge clk);
    check("mod_off_pos10", model_word(10, 1'b0));

    // One-clock pulse: may or may not register, but must land on one of the two.
    @(negedge clk);
    dir = 1'b1; microstep = 4'd4;
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (obs === model_word(model_move(model_pos, 1'b1, 4'd4), 1'b0))
      model_pos = model_move(model_pos, 1'b1, 4'd4);
    assert (obs === model_word(model_pos, 1'b0))
    else begin
      miscompares++;
      $error("FAIL narrow_pulse: observed %b expected %b", obs, model_word(model_pos, 1'b0));
    end

    // Two-clock pulse must register.
    pulse("wide_pulse", 1'b1, 4'd4, 1'b0);

    // Reset coincides with the detected step edge: the step is discarded.
    pulse("pre_rst", 1'b1, 4'd1, 1'b0);
    @(negedge clk);
    dir = 1'b1; microstep = 4'd4;
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    step = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_pos = 2;
    check("rst_vs_step", model_word(model_pos, 1'b0));
    repeat (3) @(negedge clk);
    check("rst_vs_step_hold", model_word(model_pos, 1'b0));

    pulse("post_rst", 1'b0, 4'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
